bit_serializer: RTL

Parallel-to-serial front end for the bit-serial sequence detector. Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock on `x_out`, which connects directly to the detector's serial input. Supports gapless back-to-back words, so a continuous bit stream reaches the detector with no idle bits inserted between frames.

---
 rtl/serializer_pkg.sv | 11 +
 rtl/bit_serializer.sv | 96 +++++++++
 2 files changed

// File: rtl/serializer_pkg.sv
// Shared types and constants for the parallel-to-serial front end.
package serializer_pkg;

    typedef enum logic {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_t;

    localparam int SER_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: accepts a word over valid/ready and shifts it out
// one bit per clock, reloading in the last-bit cycle so consecutive words are gapless.
module bit_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH      = SER_WIDTH_DEFAULT,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             x_out,
    output logic             bit_valid,
    output logic             last_bit
);

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    ser_state_t       r_state;
    ser_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] w_sreg_nxt;
    logic [WIDTH-1:0] w_sreg_shift;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_last;
    logic             w_accept;
    logic             w_head;

    // Direction only changes which end of the shift register feeds the output.
    generate
        if (MSB_FIRST) begin : g_msb
            assign w_sreg_shift = {r_sreg[WIDTH-2:0], 1'b0};
            assign w_head       = r_sreg[WIDTH-1];
        end else begin : g_lsb
            assign w_sreg_shift = {1'b0, r_sreg[WIDTH-1:1]};
            assign w_head       = r_sreg[0];
        end
    endgenerate

    assign w_last     = (r_state == SER_SHIFT) && (r_cnt == LAST_IDX);
    assign data_ready = !reset && ((r_state == SER_IDLE) || w_last);
    assign w_accept   = data_valid && data_ready;

    assign x_out     = (r_state == SER_SHIFT) ? w_head : IDLE_LEVEL;
    assign bit_valid = (r_state == SER_SHIFT);
    assign last_bit  = w_last;

    always_comb begin
        w_state_nxt = r_state;
        w_sreg_nxt  = r_sreg;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            SER_IDLE: begin
                if (w_accept) begin
                    w_sreg_nxt  = data_in;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SER_SHIFT;
                end
            end
            SER_SHIFT: begin
                if (w_last) begin
                    if (w_accept) begin
                        w_sreg_nxt = data_in;
                        w_cnt_nxt  = '0;
                    end else begin
                        w_sreg_nxt  = w_sreg_shift;
                        w_cnt_nxt   = '0;
                        w_state_nxt = SER_IDLE;
                    end
                end else begin
                    w_sreg_nxt = w_sreg_shift;
                    w_cnt_nxt  = r_cnt + CW'(1);
                end
            end
            default: w_state_nxt = SER_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SER_IDLE;
            r_sreg  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sreg  <= w_sreg_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule
